// File: rtl/lane_renderer.sv
// Pixel stage after the VGA timing controller: scrolling car lanes, player sprite, registered RGB and syncs.
// Optional hit detection is built when the COLLISION_EN macro is defined; otherwise collision is tied low.
module lane_renderer (
  input  logic        pclk,
  input  logic        reset,
  input  logic        valid,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic [3:0]  lane,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [9:0]  player_x,
  input  logic [3:0]  player_lane,
  output logic [11:0] rgb,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        collision
);

  localparam logic [11:0] COL_BLACK  = 12'h000;
  localparam logic [11:0] COL_PLAYER = 12'hFF0;
  localparam logic [11:0] COL_CAR_O  = 12'hF00;
  localparam logic [11:0] COL_CAR_E  = 12'h00F;
  localparam logic [11:0] COL_DIV    = 12'hFFF;
  localparam logic [11:0] COL_GOAL   = 12'h0A0;
  localparam logic [11:0] COL_START  = 12'h888;
  localparam logic [11:0] COL_ROAD   = 12'h333;

  // Sync pipeline; vs_q doubles as the falling-edge detector for the frame tick.
  logic hs_q, vs_q;
  logic frame_tick;

  assign frame_tick = vs_q & ~vsync_i;

  always_ff @(posedge pclk) begin
    if (reset) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      hs_q <= hsync_i;
      vs_q <= vsync_i;
    end
  end

  assign hsync_o = hs_q;
  assign vsync_o = vs_q;

  // Player position is sampled only at the tick so the sprite never tears.
  logic [9:0] px_q, px_d;
  logic [3:0] pl_q, pl_d;

  always_comb begin
    px_d = px_q;
    pl_d = pl_q;
    if (frame_tick) begin
      px_d = player_x;
      pl_d = player_lane;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      px_q <= 10'd0;
      pl_q <= 4'd11;
    end else begin
      px_q <= px_d;
      pl_q <= pl_d;
    end
  end

  // Lane scroll offsets, kept strictly in 0..639 by exact modulo-640 wrap.
  logic [9:0]  off_q [1:10];
  logic [9:0]  off_d [1:10];
  logic [9:0]  spd;
  logic [10:0] fwd_sum;

  always_comb begin
    off_d   = off_q;
    spd     = 10'd0;
    fwd_sum = 11'd0;
    if (frame_tick) begin
      for (int n = 1; n <= 10; n++) begin
        spd = 10'((n % 4) + 1);
        if ((n % 2) == 1) begin
          off_d[n] = (off_q[n] < spd) ? (off_q[n] + 10'd640 - spd) : (off_q[n] - spd);
        end else begin
          fwd_sum  = {1'b0, off_q[n]} + {1'b0, spd};
          off_d[n] = (fwd_sum >= 11'd640) ? 10'(fwd_sum - 11'd640) : fwd_sum[9:0];
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int n = 1; n <= 10; n++) off_q[n] <= 10'd0;
    end else begin
      for (int n = 1; n <= 10; n++) off_q[n] <= off_d[n];
    end
  end

  // Per-pixel scene decode.
  logic        traffic_lane;
  logic [9:0]  cur_off;
  logic [9:0]  lane_base;
  logic [9:0]  row;
  logic [10:0] pos_sum;
  logic [10:0] pos;
  logic [10:0] px_end;
  logic        car_x, car_pix, player_pix, divider_pix;

  always_comb begin
    cur_off = 10'd0;
    for (int n = 1; n <= 10; n++) begin
      if (lane == 4'(n)) cur_off = off_q[n];
    end
  end

  always_comb begin
    traffic_lane = (lane >= 4'd1) && (lane <= 4'd10);
    lane_base    = 10'({lane, 5'b0}) + 10'({lane, 3'b0});
    row          = v_cnt - lane_base;
    pos_sum      = {1'b0, h_cnt} + {1'b0, cur_off};
    pos          = (pos_sum >= 11'd640) ? (pos_sum - 11'd640) : pos_sum;
    car_x        = (pos < 11'd64) ||
                   ((pos >= 11'd160) && (pos < 11'd224)) ||
                   ((pos >= 11'd320) && (pos < 11'd384)) ||
                   ((pos >= 11'd480) && (pos < 11'd544));
    car_pix      = traffic_lane && (row >= 10'd8) && (row < 10'd32) && car_x;
    px_end       = {1'b0, px_q} + 11'd32;
    player_pix   = (lane == pl_q) && (row >= 10'd4) && (row < 10'd36) &&
                   (h_cnt >= px_q) && ({1'b0, h_cnt} < px_end);
    divider_pix  = (lane >= 4'd2) && (lane <= 4'd10) && (row == 10'd0) && !h_cnt[4];
  end

  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = COL_ROAD;
    if (!valid || (lane == 4'd15)) rgb_d = COL_BLACK;
    else if (player_pix)           rgb_d = COL_PLAYER;
    else if (car_pix && lane[0])   rgb_d = COL_CAR_O;
    else if (car_pix)              rgb_d = COL_CAR_E;
    else if (divider_pix)          rgb_d = COL_DIV;
    else if (lane == 4'd0)         rgb_d = COL_GOAL;
    else if (lane == 4'd11)        rgb_d = COL_START;
  end

  always_ff @(posedge pclk) begin
    if (reset) rgb_q <= COL_BLACK;
    else       rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;

`ifdef COLLISION_EN
  // A set landing on the tick cycle wins over the clear.
  logic hit_q, hit_d, coll_q, coll_d, hit_set;

  assign hit_set = valid && player_pix && car_pix;

  always_comb begin
    hit_d  = hit_q;
    coll_d = 1'b0;
    if (frame_tick) begin
      coll_d = hit_q;
      hit_d  = 1'b0;
    end
    if (hit_set) hit_d = 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      hit_q  <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      hit_q  <= hit_d;
      coll_q <= coll_d;
    end
  end

  assign collision = coll_q;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_lane_renderer.sv
// Directed bench for lane_renderer: colour table, scrolling, player latch, collision pulse and sync alignment.
module tb_lane_renderer;

  logic        pclk = 1'b0;
  logic        reset;
  logic        valid;
  logic [9:0]  h_cnt, v_cnt;
  logic [3:0]  lane;
  logic        hsync_i, vsync_i;
  logic [9:0]  player_x;
  logic [3:0]  player_lane;
  logic [11:0] rgb;
  logic        hsync_o, vsync_o, collision;

  always #20 pclk = ~pclk;

  lane_renderer dut (
    .pclk(pclk), .reset(reset), .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .lane(lane), .hsync_i(hsync_i), .vsync_i(vsync_i), .player_x(player_x),
    .player_lane(player_lane), .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .collision(collision)
  );

  typedef struct packed {
    logic        valid;
    logic [3:0]  lane;
    logic [9:0]  v;
    logic [9:0]  h;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t       tbl [23];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] exp_q [$];
  logic [1:0] prev_sync, exp_sync;
  logic       exp_coll;

`ifdef COLLISION_EN
  initial exp_coll = 1'b1;
`else
  initial exp_coll = 1'b0;
`endif

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic pix_check(input string name, input logic vld, input logic [3:0] ln,
                           input logic [9:0] v, input logic [9:0] h, input logic [11:0] exp);
    valid = vld; lane = ln; v_cnt = v; h_cnt = h;
    step();
    check(name, rgb, exp);
  endtask

  task automatic tick();
    valid = 1'b0;
    vsync_i = 1'b0;
    step();
    vsync_i = 1'b1;
    step();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'd0,  10'd5,   10'd100, 12'h0A0};
    tbl[1]  = '{1'b1, 4'd11, 10'd450, 10'd100, 12'h888};
    tbl[2]  = '{1'b1, 4'd11, 10'd450, 10'd10,  12'hFF0};
    tbl[3]  = '{1'b1, 4'd11, 10'd444, 10'd10,  12'hFF0};
    tbl[4]  = '{1'b1, 4'd11, 10'd443, 10'd10,  12'h888};
    tbl[5]  = '{1'b1, 4'd2,  10'd80,  10'd5,   12'hFFF};
    tbl[6]  = '{1'b1, 4'd2,  10'd80,  10'd16,  12'h333};
    tbl[7]  = '{1'b1, 4'd2,  10'd90,  10'd100, 12'h333};
    tbl[8]  = '{1'b1, 4'd2,  10'd90,  10'd10,  12'h00F};
    tbl[9]  = '{1'b0, 4'd1,  10'd50,  10'd10,  12'h000};
    tbl[10] = '{1'b1, 4'd15, 10'd50,  10'd10,  12'h000};
    tbl[11] = '{1'b1, 4'd1,  10'd40,  10'd5,   12'h333};
    tbl[12] = '{1'b1, 4'd1,  10'd47,  10'd10,  12'h333};
    tbl[13] = '{1'b1, 4'd1,  10'd48,  10'd10,  12'hF00};
    tbl[14] = '{1'b1, 4'd1,  10'd71,  10'd10,  12'hF00};
    tbl[15] = '{1'b1, 4'd1,  10'd72,  10'd10,  12'h333};
    tbl[16] = '{1'b1, 4'd1,  10'd50,  10'd159, 12'h333};
    tbl[17] = '{1'b1, 4'd1,  10'd50,  10'd160, 12'hF00};
    tbl[18] = '{1'b1, 4'd1,  10'd50,  10'd543, 12'hF00};
    tbl[19] = '{1'b1, 4'd1,  10'd50,  10'd544, 12'h333};
    tbl[20] = '{1'b1, 4'd10, 10'd410, 10'd639, 12'h333};
    tbl[21] = '{1'b1, 4'd10, 10'd400, 10'd0,   12'hFFF};
    tbl[22] = '{1'b1, 4'd11, 10'd440, 10'd0,   12'h888};

    reset = 1'b1; valid = 1'b1; lane = 4'd1; v_cnt = 10'd50; h_cnt = 10'd10;
    hsync_i = 1'b1; vsync_i = 1'b1; player_x = 10'd0; player_lane = 4'd11;

    // Reset state, then the first car pixel of lane 1.
    repeat (3) step();
    check("reset_rgb", rgb, 12'h000);
    check("reset_hsync", 12'(hsync_o), 12'h1);
    check("reset_vsync", 12'(vsync_o), 12'h1);
    check("reset_coll", 12'(collision), 12'h0);
    reset = 1'b0;
    pix_check("post_reset_car", 1'b1, 4'd1, 10'd50, 10'd10, 12'hF00);

    for (int i = 0; i < 23; i++) begin
      pix_check($sformatf("vec%0d", i), tbl[i].valid, tbl[i].lane, tbl[i].v, tbl[i].h, tbl[i].exp_rgb);
    end

    // One tick: off[1]=638, off[2]=3, off[4]=1.
    pix_check("pre_tick_l4", 1'b1, 4'd4, 10'd170, 10'd63, 12'h00F);
    tick();
    pix_check("scroll_l1_h1", 1'b1, 4'd1, 10'd50, 10'd1, 12'h333);
    pix_check("scroll_l1_h2", 1'b1, 4'd1, 10'd50, 10'd2, 12'hF00);
    pix_check("scroll_l2_h61", 1'b1, 4'd2, 10'd90, 10'd61, 12'h333);
    pix_check("scroll_l2_h157", 1'b1, 4'd2, 10'd90, 10'd157, 12'h00F);
    pix_check("scroll_l4_h63", 1'b1, 4'd4, 10'd170, 10'd63, 12'h333);

    // Player moves only at the tick.
    player_x = 10'd100; player_lane = 4'd3;
    pix_check("player_pre_tick", 1'b1, 4'd3, 10'd130, 10'd110, 12'h333);
    tick();
    pix_check("player_hit", 1'b1, 4'd3, 10'd130, 10'd110, 12'hFF0);
    pix_check("player_right_in", 1'b1, 4'd3, 10'd130, 10'd131, 12'hFF0);
    pix_check("player_right_out", 1'b1, 4'd3, 10'd130, 10'd132, 12'h333);
    pix_check("player_left_out", 1'b1, 4'd3, 10'd130, 10'd99, 12'h333);
    pix_check("player_row35", 1'b1, 4'd3, 10'd155, 10'd110, 12'hFF0);
    pix_check("player_row36", 1'b1, 4'd3, 10'd156, 10'd110, 12'h333);

    // 320 ticks total bring off[1] back to exactly 0; player lands at lane 1, x 0.
    player_x = 10'd0; player_lane = 4'd1;
    repeat (318) tick();
    pix_check("wrap_l1_h63", 1'b1, 4'd1, 10'd50, 10'd63, 12'hF00);
    pix_check("wrap_l1_h64", 1'b1, 4'd1, 10'd50, 10'd64, 12'h333);
    check("coll_idle", 12'(collision), 12'h0);
    pix_check("player_over_car", 1'b1, 4'd1, 10'd50, 10'd10, 12'hFF0);

    valid = 1'b0;
    vsync_i = 1'b0;
    step();
    check("coll_pulse", 12'(collision), 12'(exp_coll));
    vsync_i = 1'b1;
    step();
    check("coll_one_cycle", 12'(collision), 12'h0);
    vsync_i = 1'b0;
    step();
    check("coll_next_frame", 12'(collision), 12'h0);
    vsync_i = 1'b1;
    step();

    // Sync alignment with random sync patterns.
    prev_sync = {hsync_o, vsync_o};
    for (int i = 0; i < 16; i++) begin
      hsync_i = 1'($urandom_range(0, 1));
      vsync_i = 1'($urandom_range(0, 1));
      exp_q.push_back({hsync_i, vsync_i});
      #1;
      check($sformatf("sync_hold%0d", i), 12'({hsync_o, vsync_o}), 12'(prev_sync));
      step();
      exp_sync = exp_q.pop_front();
      check($sformatf("sync_delay%0d", i), 12'({hsync_o, vsync_o}), 12'(exp_sync));
      prev_sync = exp_sync;
    end

    // Reset mid-line clears outputs on the next edge.
    hsync_i = 1'b0; vsync_i = 1'b0;
    pix_check("midline_car", 1'b1, 4'd1, 10'd50, 10'd100, 12'h333);
    check("midline_hsync", 12'(hsync_o), 12'h0);
    reset = 1'b1;
    step();
    check("midreset_rgb", rgb, 12'h000);
    check("midreset_hsync", 12'(hsync_o), 12'h1);
    check("midreset_vsync", 12'(vsync_o), 12'h1);
    check("midreset_coll", 12'(collision), 12'h0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
